// File: rtl/load_unit.sv
// load_unit: load path that reads one aligned memory word over a req/ack bus,
// then returns the addressed byte, halfword or word with sign or zero extension.
module load_unit (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_req,
    input  logic [2:0]  I_loadsel,
    input  logic [31:0] I_addr,
    output logic        O_busy,
    output logic        O_mem_req,
    output logic [31:0] O_mem_addr,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_rdata,
    output logic        O_valid,
    output logic [31:0] O_data,
    output logic        O_error
);
    typedef enum logic [1:0] {IDLE, MEM, DONE, ERR} state_t;
    state_t      state;
    logic [1:0]  lane;
    logic [2:0]  sel;
    logic        bad;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] fmt;
    // sel[2] marks the unsigned variants; sel[1] is only set for LW once illegal selects are rejected
    always_comb begin
        bad = I_loadsel[1:0] == 2'b11 || I_loadsel[2:1] == 2'b11 ||
              (I_loadsel[1:0] == 2'b01 && I_addr[0]) ||
              (I_loadsel[1:0] == 2'b10 && I_addr[1:0] != 2'b00);
        b = lane[1] ? (lane[0] ? I_mem_rdata[31:24] : I_mem_rdata[23:16])
                    : (lane[0] ? I_mem_rdata[15:8] : I_mem_rdata[7:0]);
        h = lane[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
        fmt = sel[1] ? I_mem_rdata
            : sel[0] ? {{16{h[15] & ~sel[2]}}, h}
                     : {{24{b[7] & ~sel[2]}}, b};
    end
    assign O_busy    = state != IDLE;
    assign O_mem_req = state == MEM;
    assign O_valid   = state == DONE;
    assign O_error   = state == ERR;
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state      <= IDLE;
            lane       <= 2'b00;
            sel        <= 3'b000;
            O_mem_addr <= 32'h0;
            O_data     <= 32'h0;
        end else begin
            case (state)
                IDLE: if (I_req) begin
                    state <= bad ? ERR : MEM;
                    if (!bad) begin
                        lane       <= I_addr[1:0];
                        sel        <= I_loadsel;
                        O_mem_addr <= {I_addr[31:2], 2'b00};
                    end
                end
                MEM: if (I_mem_ack) begin
                    O_data <= fmt;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed and random loads checked against an arithmetic model of RISC-V load semantics.
module tb_load_unit;
    logic        I_clk = 1'b0;
    logic        I_rst_n;
    logic        I_req;
    logic [2:0]  I_loadsel;
    logic [31:0] I_addr;
    logic        O_busy;
    logic        O_mem_req;
    logic [31:0] O_mem_addr;
    logic        I_mem_ack;
    logic [31:0] I_mem_rdata;
    logic        O_valid;
    logic [31:0] O_data;
    logic        O_error;

    int passes = 0;
    int total = 0;
    int cyc = 0;
    int valid_cyc = 0;
    logic [31:0] model_data = 32'h0;

    load_unit dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_req(I_req), .I_loadsel(I_loadsel),
        .I_addr(I_addr), .O_busy(O_busy), .O_mem_req(O_mem_req), .O_mem_addr(O_mem_addr),
        .I_mem_ack(I_mem_ack), .I_mem_rdata(I_mem_rdata), .O_valid(O_valid),
        .O_data(O_data), .O_error(O_error)
    );

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int size_of(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit exp_bad(input logic [2:0] s, input logic [31:0] a);
        int sz = size_of(s);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] exp_val(input logic [2:0] s, input logic [31:0] a, input logic [31:0] w);
        int sz = size_of(s);
        longint span, v;
        if (sz == 4) return w;
        span = longint'(1) << (8 * sz);
        v = longint'(w >> (8 * (a % 4))) % span;
        if (s < 3'd4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // Issue one load; d = ack delay in cycles, poke = re-request while in MEM
    task automatic do_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] w,
                           input int d, input bit poke);
        logic [31:0] e;
        I_req = 1'b1; I_loadsel = s; I_addr = a;
        step();
        I_req = 1'b0; I_loadsel = 3'($urandom); I_addr = $urandom;
        if (exp_bad(s, a)) begin
            chk("err_pulse", {31'b0, O_error}, 32'd1);
            chk("err_busy", {31'b0, O_busy}, 32'd1);
            chk("err_no_memreq", {31'b0, O_mem_req}, 32'd0);
            chk("err_data_held", O_data, model_data);
            step();
            chk("err_clear", {31'b0, O_error}, 32'd0);
            chk("err_idle", {31'b0, O_busy}, 32'd0);
            chk("err_no_memreq2", {31'b0, O_mem_req}, 32'd0);
            chk("err_data_held2", O_data, model_data);
        end else begin
            e = exp_val(s, a, w);
            for (int i = 0; i <= d; i++) begin
                chk("mem_req", {31'b0, O_mem_req}, 32'd1);
                chk("mem_addr", O_mem_addr, a & 32'hFFFF_FFFC);
                chk("mem_busy", {31'b0, O_busy}, 32'd1);
                chk("mem_no_valid", {31'b0, O_valid}, 32'd0);
                if (poke && i == 0) begin
                    I_req = 1'b1; I_loadsel = 3'b000; I_addr = 32'h300;
                end
                I_mem_ack = (i == d);
                I_mem_rdata = (i == d) ? w : $urandom;
                step();
                I_req = 1'b0; I_mem_ack = 1'b0; I_mem_rdata = $urandom;
            end
            chk("valid", {31'b0, O_valid}, 32'd1);
            chk("data", O_data, e);
            chk("done_no_memreq", {31'b0, O_mem_req}, 32'd0);
            chk("done_busy", {31'b0, O_busy}, 32'd1);
            valid_cyc = cyc;
            model_data = e;
            step();
            chk("valid_single", {31'b0, O_valid}, 32'd0);
            chk("idle_busy", {31'b0, O_busy}, 32'd0);
            chk("data_held", O_data, model_data);
            if (poke) begin
                step();
                chk("poke_no_memreq", {31'b0, O_mem_req}, 32'd0);
                chk("poke_no_valid", {31'b0, O_valid}, 32'd0);
            end
        end
    endtask

    typedef struct { logic [2:0] s; logic [31:0] a; logic [31:0] e; } tp_t;
    tp_t tp[6] = '{
        '{3'd0, 32'h100, 32'h0000_0001},
        '{3'd0, 32'h103, 32'hFFFF_FF80},
        '{3'd4, 32'h103, 32'h0000_0080},
        '{3'd1, 32'h102, 32'hFFFF_80FF},
        '{3'd5, 32'h102, 32'h0000_80FF},
        '{3'd2, 32'h100, 32'h80FF_7F01}
    };

    initial begin
        int v1;
        I_rst_n = 1'b0; I_req = 1'b0; I_loadsel = 3'd0; I_addr = 32'h0;
        I_mem_ack = 1'b0; I_mem_rdata = 32'h0;
        step(); step();
        chk("rst_busy", {31'b0, O_busy}, 32'd0);
        chk("rst_memreq", {31'b0, O_mem_req}, 32'd0);
        chk("rst_memaddr", O_mem_addr, 32'd0);
        chk("rst_valid", {31'b0, O_valid}, 32'd0);
        chk("rst_data", O_data, 32'd0);
        chk("rst_error", {31'b0, O_error}, 32'd0);
        @(negedge I_clk) I_rst_n = 1'b1;
        step();

        foreach (tp[i]) begin
            do_load(tp[i].s, tp[i].a, 32'h80FF_7F01, i % 2, 1'b0);
            chk("tp_const", O_data, tp[i].e);
        end

        do_load(3'd2, 32'h200, 32'hCAFE_F00D, 3, 1'b0);

        do_load(3'd2, 32'h102, 32'h1234_5678, 0, 1'b0);
        do_load(3'd1, 32'h101, 32'h1234_5678, 0, 1'b0);
        do_load(3'd3, 32'h100, 32'h1234_5678, 0, 1'b0);
        do_load(3'd0, 32'h101, 32'h1234_5678, 0, 1'b0);
        chk("lb_101_const", O_data, 32'h0000_0056);

        do_load(3'd2, 32'h280, 32'h0BAD_BEEF, 2, 1'b1);
        chk("busy_ignore_data", O_data, 32'h0BAD_BEEF);

        I_req = 1'b1; I_loadsel = 3'd2; I_addr = 32'h40;
        step();
        I_req = 1'b0;
        chk("pre_rst_memreq", {31'b0, O_mem_req}, 32'd1);
        #2 I_rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, O_busy}, 32'd0);
        chk("arst_memreq", {31'b0, O_mem_req}, 32'd0);
        chk("arst_memaddr", O_mem_addr, 32'd0);
        chk("arst_valid", {31'b0, O_valid}, 32'd0);
        chk("arst_data", O_data, 32'd0);
        chk("arst_error", {31'b0, O_error}, 32'd0);
        model_data = 32'h0;
        @(negedge I_clk) I_rst_n = 1'b1;
        I_mem_ack = 1'b1; I_mem_rdata = 32'hDEAD_BEEF;
        step();
        I_mem_ack = 1'b0;
        chk("late_ack_no_valid", {31'b0, O_valid}, 32'd0);
        chk("late_ack_no_memreq", {31'b0, O_mem_req}, 32'd0);
        step();
        chk("late_ack_no_valid2", {31'b0, O_valid}, 32'd0);
        chk("late_ack_data", O_data, 32'd0);
        do_load(3'd2, 32'h40, 32'h5555_AAAA, 1, 1'b0);

        do_load(3'd2, 32'h10, 32'h1111_2222, 0, 1'b0);
        v1 = valid_cyc;
        do_load(3'd2, 32'h14, 32'h3333_4444, 0, 1'b0);
        chk("b2b_gap", 32'(valid_cyc - v1), 32'd3);

        for (int i = 0; i < 60; i++)
            do_load(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 2), 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
